la_capture_core: RTL
====================

# la_capture_core

Parametrised on-chip logic-analyser capture core. It is the next generation of the single-trigger probe capture used on the TDC/ADC test designs: configurable sample width and depth, per-bit mask/value/edge trigger with AND/OR combining, external trigger, programmable pre-trigger depth, and a valid/ready readout stream returning samples oldest-first. It sits between the probed design signals and a host-side readout agent (JTAG bridge or UART dumper).

## Interface
Parameters:
- DATA_W, 6, sample width in bits (1..64)
- DEPTH, 256, capture buffer depth in samples; power of two, 16..4096
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  capture and readout clock
- rst  in  1  synchronous active-high reset
- data_i  in  DATA_W  probed sample
- sample_en  in  1  sample qualifier; only qualified cycles are stored or trigger-evaluated
- arm  in  1  one-cycle pulse; starts a capture from IDLE, ignored elsewhere
- abort  in  1  returns to IDLE next cycle from any state
- trig_mask  in  DATA_W  1 = bit participates in trigger
- trig_value  in  DATA_W  level to match (level bits) or edge direction, 1 = rising (edge bits)
- trig_edge  in  DATA_W  1 = edge-sensitive bit, 0 = level
- trig_or  in  1  0 = AND of masked bit terms, 1 = OR
- ext_trig  in  1  external trigger, OR'd with pattern hit
- pre_trig  in  AW  samples kept before trigger sample (0..DEPTH-1)
- state_o  out  3  current state encoding
- triggered_o  out  1  trigger has fired in this capture
- done_o  out  1  buffer full, readout available
- trig_addr_o  out  AW  buffer address of trigger sample
- rd_data  out  DATA_W  readout sample
- rd_valid  out  1  readout handshake valid
- rd_ready  in  1  readout handshake ready
- rd_last  out  1  marks sample DEPTH-1 of readout

## Operation
- Config (trig_*, pre_trig) latched on accepted arm; changes afterwards ignored until next arm.
- States: IDLE(0) -> PRE(1) -> ARMED(2) -> POST(3) -> DONE(4) -> IDLE.
- IDLE: no writes. arm -> PRE, wr_ptr=0, cnt=0; if latched pre_trig=0 go directly to ARMED.
- PRE: each qualified sample written at wr_ptr, wr_ptr++ (mod DEPTH), cnt++; trigger ignored; cnt==pre_trig -> ARMED.
- ARMED: circular writes continue; qualified sample with hit -> that sample written, trig_addr=its address, post counter = DEPTH-1-pre_trig; -> POST (-> DONE directly if counter is 0).
- POST: each qualified write decrements counter; reaching 0 -> DONE. Total stored = DEPTH, exactly pre_trig before trigger sample.
- DONE: rd pointer starts at trig_addr-pre_trig (mod DEPTH); streams DEPTH samples; handshake rd_last -> IDLE.
- Trigger term per masked bit: level: data==value; edge: prev!=data and data==value. Unmasked bits excluded. AND of empty set and OR of empty set both false (mask=0 -> ext_trig only). Prev register updates on qualified samples only; cleared-invalid on arm, so edge terms are false on the first qualified sample after arm.
- abort or rst: any state -> IDLE; triggered_o, done_o, rd_valid cleared; buffer contents undefined.

## Timing
- Reset: state IDLE, triggered_o=0, done_o=0, trig_addr_o=0, rd_valid=0, rd_last=0, rd_data=0.
- Hit evaluated combinationally on the sample's cycle; state/triggered_o/trig_addr_o update registered, visible next cycle.
- Buffer: simple dual-port RAM, 1-cycle synchronous read. Readout prefetch keeps rd_data/rd_valid/rd_last stable while rd_valid && !rd_ready; first rd_valid no later than 2 cycles after done_o rises; full throughput 1 sample/cycle with rd_ready held high.
- arm in same cycle as abort: abort wins.
- Wrap-around of wr_ptr and rd pointer is mod DEPTH with no gap.

## Structure
- Package la_pkg: state enum la_state_t (IDLE..DONE, 3 bits), encoding constants for state_o.
- Sub-module la_trig_match: registered prev sample, mask/value/edge/or evaluation, outputs hit; purely combinational hit plus prev register.
- RAM inferred inside la_capture_core as a separate always block.

## Test plan
- DEPTH=16, pre_trig=4, level trigger mask=6'h01 value=6'h01, ramp data 0..; first odd sample at ARMED triggers -> readout 16 samples, 5th equals trigger sample, rd_last on 16th.
- Edge rising on bit 2, trig_or=0, data toggles bit 2 every 3 qualified samples with sample_en 50% -> trigger on first 0->1 qualified transition, not on first sample after arm.
- mask=0, ext_trig pulse after 20 samples, pre_trig=0 -> trigger sample is readout word 0, triggered_o next cycle.
- pre_trig=15 (DEPTH-1) -> DONE immediately after trigger sample; trigger sample is last readout word.
- Readout with rd_ready randomly low 50% -> all 16 words in order, no duplicates/drops, rd_data stable while stalled.
- abort during POST then arm -> clean new capture; rst mid-readout -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture core.
// Holds the state encoding that is presented on state_o and the matching state enum.
package la_pkg;

  // Numeric encodings presented on state_o.
  localparam logic [2:0] STATE_IDLE  = 3'd0;
  localparam logic [2:0] STATE_PRE   = 3'd1;
  localparam logic [2:0] STATE_ARMED = 3'd2;
  localparam logic [2:0] STATE_POST  = 3'd3;
  localparam logic [2:0] STATE_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = STATE_IDLE,
    ST_PRE   = STATE_PRE,
    ST_ARMED = STATE_ARMED,
    ST_POST  = STATE_POST,
    ST_DONE  = STATE_DONE
  } la_state_t;

endpackage

// File: rtl/la_trig_match.sv
// Pattern trigger evaluator.
// Holds the previous qualified sample and combinationally computes a pattern hit for the
// current sample from per-bit mask / value / edge selects and an AND/OR combine select.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   sample_en   qualifier; the previous-sample register only advances on qualified cycles
//   clear       invalidates the previous sample (edge terms false on the next sample)
//   data        current sample
//   mask        1 = bit takes part in the trigger
//   value       level to match, or edge direction (1 = rising) for edge bits
//   edge_sel    1 = edge-sensitive bit, 0 = level bit
//   any_sel     0 = AND of masked terms, 1 = OR of masked terms
//   hit         combinational pattern hit for the current sample
module la_trig_match #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] mask,
  input  logic [DATA_W-1:0] value,
  input  logic [DATA_W-1:0] edge_sel,
  input  logic              any_sel,
  output logic              hit
);

  logic [DATA_W-1:0] prev_reg;
  logic              prev_valid_reg;
  logic [DATA_W-1:0] term;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
    end else if (sample_en) begin
      prev_reg       <= data;
      prev_valid_reg <= 1'b1;
    end
  end

  // An edge term needs a valid previous sample that differs and a new level equal to value.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_term
    assign term[gi] = (data[gi] == value[gi]) &&
                      (!edge_sel[gi] || (prev_valid_reg && (prev_reg[gi] != data[gi])));
  end

  // Both combines are false over an empty mask, so mask=0 leaves only the external trigger.
  assign hit = any_sel ? (|(term & mask))
                       : ((&(term | ~mask)) && (|mask));

endmodule

// File: rtl/la_capture_core.sv
// On-chip logic-analyser capture core.
// Stores qualified samples in a circular buffer around a pattern/external trigger with a
// programmable number of pre-trigger samples, then streams the DEPTH-sample window
// oldest-first over a valid/ready interface.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   data_i, sample_en             probed sample and its qualifier
//   arm, abort                    start a capture from IDLE / return to IDLE
//   trig_mask/value/edge, trig_or pattern trigger configuration (latched on arm)
//   ext_trig                      external trigger, OR'd with the pattern hit
//   pre_trig                      samples kept before the trigger sample (latched on arm)
//   state_o, triggered_o, done_o  status
//   trig_addr_o                   buffer address of the trigger sample
//   rd_data, rd_valid, rd_ready, rd_last  readout stream
module la_capture_core
  import la_pkg::*;
#(
  parameter  int DATA_W = 6,
  parameter  int DEPTH  = 256,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sample_en,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] trig_edge,
  input  logic              trig_or,
  input  logic              ext_trig,
  input  logic [AW-1:0]     pre_trig,
  output logic [2:0]        state_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [AW-1:0]     trig_addr_o,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last
);

  la_state_t         state_reg, state_next;
  logic [DATA_W-1:0] mask_cfg_reg, value_cfg_reg, edge_cfg_reg;
  logic              or_cfg_reg;
  logic [AW-1:0]     pre_cfg_reg;
  logic [AW-1:0]     wr_ptr_reg, cnt_reg, post_cnt_reg, trig_addr_reg;
  logic              triggered_reg;
  logic [AW:0]       fetch_cnt_reg;
  logic              pend_reg, pend_last_reg;
  logic              skid_valid_reg, skid_last_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic              rd_valid_reg, rd_last_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic          arm_ok, pattern_hit, trig_hit, wr_en, fire, out_free, issue, fetch_left;
  logic [AW-1:0] cnt_inc, post_init, rd_addr;
  logic [1:0]    occ;

  la_trig_match #(.DATA_W(DATA_W)) u_match (
    .clk      (clk),
    .rst      (rst),
    .sample_en(sample_en),
    .clear    (arm_ok),
    .data     (data_i),
    .mask     (mask_cfg_reg),
    .value    (value_cfg_reg),
    .edge_sel (edge_cfg_reg),
    .any_sel  (or_cfg_reg),
    .hit      (pattern_hit)
  );

  assign arm_ok    = arm && !abort && (state_reg == ST_IDLE);
  assign trig_hit  = sample_en && (pattern_hit || ext_trig);
  assign wr_en     = sample_en && ((state_reg == ST_PRE) || (state_reg == ST_ARMED) ||
                                   (state_reg == ST_POST));
  assign cnt_inc   = cnt_reg + 1'b1;
  assign post_init = AW'(DEPTH - 1) - pre_cfg_reg;

  // Readout window starts pre_trig samples before the trigger; pointer arithmetic wraps mod DEPTH.
  assign rd_addr    = trig_addr_reg - pre_cfg_reg + fetch_cnt_reg[AW-1:0];
  assign fetch_left = (fetch_cnt_reg != (AW+1)'(DEPTH));
  assign fire       = rd_valid_reg && rd_ready;
  assign out_free   = !rd_valid_reg || rd_ready;
  // Words in flight (RAM read + output + skid) never exceed two, so a read is issued only
  // when it is guaranteed a slot; this sustains one word per cycle with rd_ready high.
  assign occ   = {1'b0, pend_reg} + {1'b0, rd_valid_reg} + {1'b0, skid_valid_reg};
  assign issue = (state_reg == ST_DONE) && fetch_left && (fire || (occ < 2'd2));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (arm) state_next = (pre_trig == '0) ? ST_ARMED : ST_PRE;
      ST_PRE:   if (sample_en && (cnt_inc == pre_cfg_reg)) state_next = ST_ARMED;
      ST_ARMED: if (trig_hit) state_next = (post_init == '0) ? ST_DONE : ST_POST;
      ST_POST:  if (sample_en && (post_cnt_reg == AW'(1))) state_next = ST_DONE;
      ST_DONE:  if (fire && rd_last_reg) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // Capture datapath: configuration latch, write pointer and the pre/post counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_cfg_reg  <= '0;
      value_cfg_reg <= '0;
      edge_cfg_reg  <= '0;
      or_cfg_reg    <= 1'b0;
      pre_cfg_reg   <= '0;
      wr_ptr_reg    <= '0;
      cnt_reg       <= '0;
      post_cnt_reg  <= '0;
      trig_addr_reg <= '0;
      triggered_reg <= 1'b0;
      fetch_cnt_reg <= '0;
    end else begin
      if (arm_ok) begin
        mask_cfg_reg  <= trig_mask;
        value_cfg_reg <= trig_value;
        edge_cfg_reg  <= trig_edge;
        or_cfg_reg    <= trig_or;
        pre_cfg_reg   <= pre_trig;
        wr_ptr_reg    <= '0;
        cnt_reg       <= '0;
        triggered_reg <= 1'b0;
        fetch_cnt_reg <= '0;
      end
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if ((state_reg == ST_PRE) && sample_en) cnt_reg <= cnt_inc;
      if ((state_reg == ST_ARMED) && trig_hit) begin
        trig_addr_reg <= wr_ptr_reg;
        post_cnt_reg  <= post_init;
        triggered_reg <= 1'b1;
      end
      if ((state_reg == ST_POST) && sample_en) post_cnt_reg <= post_cnt_reg - 1'b1;
      if (issue) fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
      if (abort) triggered_reg <= 1'b0;
    end
  end

  // Capture buffer: simple dual-port RAM with registered read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= data_i;
    ram_q <= mem[rd_addr];
  end

  // Readout stage: output register plus one skid word absorbs the read in flight on a stall.
  always_ff @(posedge clk) begin
    if (rst || abort || (state_reg != ST_DONE)) begin
      pend_reg       <= 1'b0;
      pend_last_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_last_reg  <= 1'b0;
      skid_data_reg  <= '0;
      rd_valid_reg   <= 1'b0;
      rd_last_reg    <= 1'b0;
      rd_data_reg    <= '0;
    end else begin
      pend_reg      <= issue;
      pend_last_reg <= (fetch_cnt_reg == (AW+1)'(DEPTH - 1));
      if (out_free) begin
        if (skid_valid_reg) begin
          rd_data_reg    <= skid_data_reg;
          rd_last_reg    <= skid_last_reg;
          rd_valid_reg   <= 1'b1;
          skid_valid_reg <= pend_reg;
          skid_data_reg  <= ram_q;
          skid_last_reg  <= pend_last_reg;
        end else begin
          rd_valid_reg <= pend_reg;
          rd_last_reg  <= pend_reg && pend_last_reg;
          if (pend_reg) rd_data_reg <= ram_q;
        end
      end else if (pend_reg) begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= ram_q;
        skid_last_reg  <= pend_last_reg;
      end
    end
  end

  assign state_o     = state_reg;
  assign triggered_o = triggered_reg;
  assign done_o      = (state_reg == ST_DONE);
  assign trig_addr_o = trig_addr_reg;
  assign rd_data     = rd_data_reg;
  assign rd_valid    = rd_valid_reg;
  assign rd_last     = rd_last_reg;

endmodule
